// File: rtl/bus_pkg.sv
// Shared bus encodings: transfer types, access sizes, response codes and slave FSM states.
package bus_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } trans_e;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'b000,
        SIZE_HALF = 3'b001,
        SIZE_WORD = 3'b010
    } size_e;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef logic [2:0] slave_state_e;

    localparam slave_state_e ST_IDLE = 3'd0;
    localparam slave_state_e ST_WAIT = 3'd1;
    localparam slave_state_e ST_DATA = 3'd2;
    localparam slave_state_e ST_ERR1 = 3'd3;
    localparam slave_state_e ST_ERR2 = 3'd4;

endpackage

// File: rtl/bus_sram_array.sv
// Word-organised register-file storage with per-byte write enables and asynchronous read.
module bus_sram_array #(
    parameter int unsigned DWidth = 32,
    parameter int unsigned Depth  = 256,
    parameter int unsigned IdxW   = $clog2(Depth)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DWidth/8-1:0]   be_i,
    input  logic [IdxW-1:0]       addr_i,
    input  logic [DWidth-1:0]     wdata_i,
    output logic [DWidth-1:0]     rdata_o
);

    localparam int unsigned NumBytes = DWidth / 8;

    logic [DWidth-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < int'(NumBytes); b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bus_sram_slave.sv
// Pipelined bus slave fronting a word-addressed SRAM: address/data phases, wait states,
// byte-lane writes and a two-cycle error response for illegal accesses.
module bus_sram_slave
    import bus_pkg::*;
#(
    parameter int unsigned       DWidth     = 32,
    parameter int unsigned       Depth      = 256,
    parameter logic [DWidth-1:0] BaseAddr   = '0,
    parameter int unsigned       WaitStates = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sel_i,
    input  logic [DWidth-1:0] addr_i,
    input  logic [1:0]        trans_i,
    input  logic              write_i,
    input  logic [2:0]        size_i,
    input  logic [DWidth-1:0] wdata_i,
    input  logic              ready_i,
    output logic [DWidth-1:0] rdata_o,
    output logic              resp_o,
    output logic              readyout_o
);

    localparam int unsigned NumBytes = DWidth / 8;
    localparam int unsigned LaneW    = $clog2(NumBytes);
    localparam int unsigned IdxW     = $clog2(Depth);
    localparam int unsigned OffW     = IdxW + LaneW;
    localparam int unsigned MemBytes = Depth * NumBytes;

    slave_state_e        state_q, state_d;
    logic [OffW-1:0]     offset_q, offset_d;
    logic                write_q, write_d;
    logic [2:0]          size_q, size_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                readyout_q, readyout_d;
    logic                resp_q, resp_d;

    logic [DWidth-1:0]   offset;
    logic                capture;
    logic                illegal;
    logic [LaneW-1:0]    lane;
    logic [NumBytes-1:0] be;
    logic                mem_we;
    logic [DWidth-1:0]   mem_rdata;

    // Address-phase decode
    assign offset  = addr_i - BaseAddr;
    assign capture = sel_i && ready_i && (trans_i == TRANS_NONSEQ || trans_i == TRANS_SEQ);

    always_comb begin
        illegal = 1'b0;
        if (offset >= DWidth'(MemBytes)) illegal = 1'b1;
        if (size_i > SIZE_WORD) illegal = 1'b1;
        if (size_i == SIZE_HALF && addr_i[0]) illegal = 1'b1;
        if (size_i == SIZE_WORD && addr_i[LaneW-1:0] != '0) illegal = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        write_d  = write_q;
        size_d   = size_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all accept the next address phase
                state_d = ST_IDLE;
                if (capture) begin
                    offset_d = offset[OffW-1:0];
                    write_d  = write_i;
                    size_d   = size_i;
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else if (WaitStates == 0) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WaitStates - 1);
                    end
                end
            end
        endcase
        readyout_d = !(state_d == ST_WAIT || state_d == ST_ERR1);
        resp_d     = (state_d == ST_ERR1 || state_d == ST_ERR2) ? RESP_ERROR : RESP_OKAY;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            offset_q   <= '0;
            write_q    <= 1'b0;
            size_q     <= 3'd0;
            cnt_q      <= 4'd0;
            readyout_q <= 1'b1;
            resp_q     <= RESP_OKAY;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            write_q    <= write_d;
            size_q     <= size_d;
            cnt_q      <= cnt_d;
            readyout_q <= readyout_d;
            resp_q     <= resp_d;
        end
    end

    // Little-endian byte-lane enables for the latched access
    assign lane = offset_q[LaneW-1:0];

    always_comb begin
        be = '1;
        case (size_q)
            SIZE_BYTE: be = NumBytes'(1) << lane;
            SIZE_HALF: be = NumBytes'(3) << (lane & ~LaneW'(1));
            default:   be = '1;
        endcase
    end

    assign mem_we = (state_q == ST_DATA) && write_q && !rst_i;

    bus_sram_array #(
        .DWidth (DWidth),
        .Depth  (Depth),
        .IdxW   (IdxW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .be_i    (be),
        .addr_i  (offset_q[OffW-1:LaneW]),
        .wdata_i (wdata_i),
        .rdata_o (mem_rdata)
    );

    assign rdata_o    = (state_q == ST_DATA && !write_q) ? mem_rdata : '0;
    assign resp_o     = resp_q;
    assign readyout_o = readyout_q;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Bench for bus_sram_slave: a pipelined bus master drives two instances (0 and 3 wait states)
// and every cycle is compared against a transaction-level memory model.
module tb_bus_sram_slave;

    localparam logic [31:0] BASE      = 32'h0000_1000;
    localparam int unsigned DEPTH     = 256;
    localparam int unsigned MEM_BYTES = DEPTH * 4;

    typedef struct {
        int          kind;   // 0 real transfer, 1 sel low, 2 IDLE, 3 BUSY
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } txn_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      sel, write, readyout, resp;
    logic [1:0][31:0] addr, wdata, rdata;
    logic [1:0][1:0] trans;
    logic [1:0][2:0] size;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [2][DEPTH];
    txn_t        q[$];

    always #5 clk = ~clk;

    bus_sram_slave #(.DWidth(32), .Depth(DEPTH), .BaseAddr(BASE), .WaitStates(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .sel_i(sel[0]), .addr_i(addr[0]), .trans_i(trans[0]),
        .write_i(write[0]), .size_i(size[0]), .wdata_i(wdata[0]), .ready_i(readyout[0]),
        .rdata_o(rdata[0]), .resp_o(resp[0]), .readyout_o(readyout[0])
    );

    bus_sram_slave #(.DWidth(32), .Depth(DEPTH), .BaseAddr(BASE), .WaitStates(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .sel_i(sel[1]), .addr_i(addr[1]), .trans_i(trans[1]),
        .write_i(write[1]), .size_i(size[1]), .wdata_i(wdata[1]), .ready_i(readyout[1]),
        .rdata_o(rdata[1]), .resp_o(resp[1]), .readyout_o(readyout[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(int kind, bit wr, logic [31:0] a, logic [2:0] sz, logic [31:0] wd);
        txn_t t;
        t.kind = kind; t.wr = wr; t.addr = a; t.size = sz; t.wdata = wd;
        return t;
    endfunction

    function automatic bit is_err(txn_t t);
        logic [31:0] off = t.addr - BASE;
        return (off >= MEM_BYTES) || (t.size > 3'd2) ||
               (t.size == 3'd1 && t.addr[0]) || (t.size == 3'd2 && t.addr[1:0] != 2'b00);
    endfunction

    function automatic int widx(txn_t t);
        logic [31:0] off = t.addr - BASE;
        return int'(off[9:2]);
    endfunction

    // Little-endian model of a committed write
    function automatic void model_write(int d, txn_t t);
        logic [31:0] off = t.addr - BASE;
        int          idx = widx(t);
        int          first;
        int          nbytes;
        logic [31:0] w;
        w      = mem_m[d][idx];
        first  = (t.size == 3'd0) ? int'(off[1:0]) : (t.size == 3'd1) ? (int'(off[1:0]) & 2) : 0;
        nbytes = 1 << t.size;
        for (int b = first; b < first + nbytes; b++) w[b*8 +: 8] = t.wdata[b*8 +: 8];
        mem_m[d][idx] = w;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int   r = int'($urandom_range(0, 99));
        int   w = int'($urandom_range(0, DEPTH - 1));
        t.kind  = (r < 88) ? 0 : int'($urandom_range(1, 3));
        t.wr    = 1'($urandom);
        t.size  = 3'($urandom_range(0, 2));
        t.wdata = $urandom;
        t.addr  = BASE + 32'(w * 4);
        if (t.size == 3'd0)      t.addr += 32'($urandom_range(0, 3));
        else if (t.size == 3'd1) t.addr += 32'($urandom_range(0, 1) * 2);
        r = int'($urandom_range(0, 99));
        if (r < 5)       t.size = 3'($urandom_range(3, 7));
        else if (r < 10) t.addr = BASE + 32'(MEM_BYTES) + 32'($urandom_range(0, 4095));
        else if (r < 13) t.addr = BASE - 32'($urandom_range(1, 64));
        else if (r < 18) t.addr |= 32'($urandom_range(1, 3));
        return t;
    endfunction

    task automatic drive_idle(input int d);
        sel[d]   = 1'b0;
        trans[d] = 2'b00;
        addr[d]  = $urandom;
        write[d] = 1'($urandom);
        size[d]  = 3'd2;
    endtask

    task automatic drive_txn(input int d, input txn_t t);
        addr[d]  = t.addr;
        write[d] = t.wr;
        size[d]  = t.size;
        case (t.kind)
            0:       begin sel[d] = 1'b1; trans[d] = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10; end
            1:       begin sel[d] = 1'b0; trans[d] = 2'b10; end
            2:       begin sel[d] = 1'b1; trans[d] = 2'b00; end
            default: begin sel[d] = 1'b1; trans[d] = 2'b01; end
        endcase
    endtask

    // Pipelined master: next address phase is presented during the current data phase.
    // Entered and left #1 after a rising edge.
    task automatic run_q(input int d);
        txn_t        dp;
        bit          dp_v = 1'b0;
        int          dpc  = 0;
        int          ws   = (d == 0) ? 0 : 3;
        bit          err;
        bit          rdy_e;
        bit          rdy_s;
        logic [31:0] rd_e;
        while (q.size() > 0 || dp_v) begin
            if (q.size() > 0) drive_txn(d, q[0]);
            else              drive_idle(d);
            wdata[d] = dp_v ? dp.wdata : 32'($urandom);
            @(negedge clk);
            err = dp_v && is_err(dp);
            if (!dp_v) begin
                rdy_e = 1'b1; rd_e = 32'd0;
            end else if (err) begin
                rdy_e = (dpc == 1); rd_e = 32'd0;
            end else begin
                rdy_e = (dpc >= ws);
                rd_e  = (!dp.wr && dpc >= ws) ? mem_m[d][widx(dp)] : 32'd0;
            end
            check($sformatf("readyout[%0d]", d), 32'(readyout[d]), 32'(rdy_e));
            check($sformatf("resp[%0d]", d), 32'(resp[d]), 32'(err));
            check($sformatf("rdata[%0d]", d), rdata[d], rd_e);
            rdy_s = readyout[d];
            @(posedge clk); #1;
            if (rdy_s) begin
                if (dp_v && !err && dp.wr) model_write(d, dp);
                dp_v = 1'b0;
                if (q.size() > 0) begin
                    txn_t a = q.pop_front();
                    if (a.kind == 0) begin dp = a; dp_v = 1'b1; dpc = 0; end
                end
            end else begin
                dpc++;
                if (dpc > 8) begin
                    checks++; errors++;
                    $error("FAIL ready_timeout[%0d]: observed=%0d stall cycles expected<=%0d", d, dpc, ws);
                    dp_v = 1'b0;
                    q.delete();
                end
            end
        end
        drive_idle(d);
    endtask

    task automatic check_reset_outputs(input string tag, input int d);
        check({tag, "_readyout"}, 32'(readyout[d]), 32'd1);
        check({tag, "_resp"}, 32'(resp[d]), 32'd0);
        check({tag, "_rdata"}, rdata[d], 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin drive_idle(d); wdata[d] = 32'd0; end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) check_reset_outputs($sformatf("reset[%0d]", d), d);
        rst = 1'b0;

        // Fill every word so later reads have a known model value
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < int'(DEPTH); i++) q.push_back(mk(0, 1'b1, BASE + 32'(i * 4), 3'd2, $urandom));
            run_q(d);
        end

        // Write then back-to-back read of the same word
        q.push_back(mk(0, 1'b1, BASE + 32'h8, 3'd2, 32'hDEADBEEF));
        q.push_back(mk(0, 1'b0, BASE + 32'h8, 3'd2, 32'd0));
        run_q(0);
        check("model_deadbeef", mem_m[0][2], 32'hDEADBEEF);

        // Wait-state read with the next address phase held during the stall
        q.push_back(mk(0, 1'b0, BASE + 32'h4, 3'd2, 32'd0));
        q.push_back(mk(0, 1'b0, BASE + 32'h8, 3'd2, 32'd0));
        run_q(1);

        // Byte and halfword lane writes
        for (int d = 0; d < 2; d++) begin
            q.push_back(mk(0, 1'b1, BASE + 32'h10, 3'd2, 32'h11223344));
            q.push_back(mk(0, 1'b1, BASE + 32'h11, 3'd0, 32'hAAAAAAAA));
            q.push_back(mk(0, 1'b0, BASE + 32'h10, 3'd2, 32'd0));
            q.push_back(mk(0, 1'b1, BASE + 32'h12, 3'd1, 32'h5A5A5A5A));
            q.push_back(mk(0, 1'b0, BASE + 32'h10, 3'd2, 32'd0));
            run_q(d);
        end

        // Out-of-range read, misaligned half write, then confirm memory untouched
        for (int d = 0; d < 2; d++) begin
            q.push_back(mk(0, 1'b0, BASE + 32'(MEM_BYTES), 3'd2, 32'd0));
            q.push_back(mk(0, 1'b1, BASE + 32'h3, 3'd1, 32'hFFFFFFFF));
            q.push_back(mk(0, 1'b0, BASE + 32'h0, 3'd2, 32'd0));
            run_q(d);
        end

        // Ignored address phases (sel low, IDLE, BUSY) must not write
        for (int d = 0; d < 2; d++) begin
            q.push_back(mk(1, 1'b1, BASE + 32'h20, 3'd2, 32'hCAFE0001));
            q.push_back(mk(2, 1'b1, BASE + 32'h20, 3'd2, 32'hCAFE0002));
            q.push_back(mk(3, 1'b1, BASE + 32'h20, 3'd2, 32'hCAFE0003));
            q.push_back(mk(0, 1'b0, BASE + 32'h20, 3'd2, 32'd0));
            run_q(d);
        end

        // Randomized traffic
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 200; i++) q.push_back(rand_txn());
            run_q(d);
        end

        // Reset during the second wait cycle of a write aborts it
        q.push_back(mk(0, 1'b1, BASE + 32'h40, 3'd2, 32'h5555AAAA));
        run_q(1);
        drive_txn(1, mk(0, 1'b1, BASE + 32'h40, 3'd2, 32'd0));
        @(posedge clk); #1;
        drive_idle(1);
        wdata[1] = 32'h12345678;
        @(negedge clk);
        check("rst_wait1_readyout", 32'(readyout[1]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_wait2_readyout", 32'(readyout[1]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("rst_abort", 1);
        q.push_back(mk(0, 1'b0, BASE + 32'h40, 3'd2, 32'd0));
        run_q(1);
        check("rst_abort_model", mem_m[1][16], 32'h5555AAAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
